// File: rtl/apb_chk_pkg.sv
// Shared types and constants for the APB protocol checker: bus phase enum,
// violation index enum (doubles as err_sticky bit position), counter widths
// and the lowest-index violation encoder.
package apb_chk_pkg;

  localparam int NUM_VIOL   = 7;
  localparam int XFER_CNT_W = 16;
  localparam int ERR_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  typedef enum logic [2:0] {
    V_MULTI_SEL   = 3'd0,
    V_EN_NO_SETUP = 3'd1,
    V_NO_ACCESS   = 3'd2,
    V_UNSTABLE    = 3'd3,
    V_DROP        = 3'd4,
    V_TIMEOUT     = 3'd5,
    V_STRB        = 3'd6
  } viol_e;

  // Lowest set bit wins when several violations land in the same cycle.
  function automatic viol_e lowest_viol(input logic [NUM_VIOL-1:0] v);
    lowest_viol = V_MULTI_SEL;
    for (int i = NUM_VIOL - 1; i >= 0; i--) begin
      if (v[i]) lowest_viol = viol_e'(i[2:0]);
    end
  endfunction

endpackage

// File: rtl/apb_protocol_checker_if.sv
// APB bus segment signals. The checker uses the monitor modport (all inputs);
// master and slave modports describe the real endpoints on the same segment.
interface apb_protocol_checker_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SEL    = 1
);
  logic [NUM_SEL-1:0]      PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic                    PREADY;
  logic                    PSLVERR;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PSLVERR
  );

  modport monitor (
    input PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_chk_satcnt.sv
// Saturating up-counter with synchronous clear. An increment coinciding with
// clear leaves the counter at 1 so the same-cycle event is not lost.
module apb_chk_satcnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: clear first, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? WIDTH'(1) : '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/apb_protocol_checker.sv
// Passive APB protocol checker. Classifies every sampled cycle against the
// IDLE/SETUP/ACCESS sequence, flags violations as a registered pulse with
// lowest-index code and captured address, keeps sticky flags and saturating
// transfer/error counters.
// Optional feature macro APB_CHK_STRB_EN: enables the read-with-strobes check
// (violation 6) and adds PSTRB to the stability comparison. Without it PSTRB
// is ignored and err_sticky[6] stays 0.
// state_q records the phase of the previously sampled cycle: ST_SETUP means
// the current cycle must be the first ACCESS, ST_ACCESS means a wait state
// was seen and the transfer is still open.
module apb_protocol_checker
  import apb_chk_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SEL    = 1,
  parameter int TIMEOUT    = 16
) (
  input  logic                   PCLK,
  input  logic                   RESET,
  apb_protocol_checker_if.monitor apb,
  input  logic                   clear,
  output logic                   err_pulse,
  output logic [2:0]             err_code,
  output logic [ADDR_WIDTH-1:0]  err_addr,
  output logic [NUM_VIOL-1:0]    err_sticky,
  output logic [XFER_CNT_W-1:0]  xfer_count,
  output logic [ERR_CNT_W-1:0]   err_count
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  apb_state_e state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic [NUM_VIOL-1:0]   viol;
  logic                  cap_en;
  logic                  complete;
  logic                  sel_any;
  logic                  multi_sel;
  logic                  changed;
  logic                  strb_changed;
  logic                  strb_bad;

  logic [NUM_SEL-1:0]    sel_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  err_pulse_q;
  logic [2:0]            err_code_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;
  logic [NUM_VIOL-1:0]   err_sticky_q;

  assign sel_any   = |apb.PSEL;
  assign multi_sel = (apb.PSEL & (apb.PSEL - NUM_SEL'(1))) != '0;

`ifdef APB_CHK_STRB_EN
  logic [DATA_WIDTH/8-1:0] strb_q;
  assign strb_changed = (apb.PSTRB != strb_q);
  assign strb_bad     = !apb.PWRITE && (apb.PSTRB != '0);
`else
  assign strb_changed = 1'b0;
  assign strb_bad     = 1'b0;
`endif

  // Any change of the transfer attributes since the previous transfer cycle;
  // write data only matters for writes.
  assign changed = (apb.PSEL != sel_q) || (apb.PADDR != addr_q) ||
                   (apb.PWRITE != write_q) ||
                   (write_q && (apb.PWDATA != wdata_q)) || strb_changed;

  // Phase classification, violation detection and wait-state counting.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    cap_en   = 1'b0;
    complete = 1'b0;
    viol     = '0;
    viol[V_MULTI_SEL] = multi_sel;
    unique case (state_q)
      ST_IDLE: begin
        viol[V_EN_NO_SETUP] = apb.PENABLE;
        if (sel_any && !apb.PENABLE) begin
          state_d        = ST_SETUP;
          cap_en         = 1'b1;
          viol[V_STRB]   = strb_bad;
        end
      end
      ST_SETUP, ST_ACCESS: begin
        if ((state_q == ST_SETUP) && !apb.PENABLE) begin
          // Missing ACCESS: restart as a fresh SETUP if still selected.
          viol[V_NO_ACCESS] = 1'b1;
          wait_d            = '0;
          if (sel_any) begin
            state_d      = ST_SETUP;
            cap_en       = 1'b1;
            viol[V_STRB] = strb_bad;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!sel_any || !apb.PENABLE) begin
          viol[V_DROP] = 1'b1;
          state_d      = ST_IDLE;
          wait_d       = '0;
        end else begin
          viol[V_UNSTABLE] = changed;
          cap_en           = 1'b1;
          if (apb.PREADY) begin
            complete = 1'b1;
            state_d  = ST_IDLE;
            wait_d   = '0;
          end else begin
            state_d = ST_ACCESS;
            if (wait_q != WAIT_W'(TIMEOUT)) wait_d = wait_q + WAIT_W'(1);
            viol[V_TIMEOUT] = (wait_q == WAIT_W'(TIMEOUT - 1));
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        wait_d  = '0;
      end
    endcase
  end

  // FSM, wait counter and registered error reporting.
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= '0;
      err_addr_q   <= '0;
      err_sticky_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      err_pulse_q  <= |viol;
      if (|viol) begin
        err_code_q <= lowest_viol(viol);
        err_addr_q <= apb.PADDR;
      end
      err_sticky_q <= (clear ? '0 : err_sticky_q) | viol;
    end
  end

  // Transfer attribute capture for the stability comparison.
  always_ff @(posedge PCLK) begin
    if (cap_en) begin
      sel_q   <= apb.PSEL;
      addr_q  <= apb.PADDR;
      write_q <= apb.PWRITE;
      wdata_q <= apb.PWDATA;
`ifdef APB_CHK_STRB_EN
      strb_q  <= apb.PSTRB;
`endif
    end
  end

  apb_chk_satcnt #(.WIDTH(XFER_CNT_W)) u_xfer_cnt (
    .clk_i   (PCLK),
    .rst_i   (RESET),
    .clr_i   (clear),
    .inc_i   (complete),
    .count_o (xfer_count)
  );

  apb_chk_satcnt #(.WIDTH(ERR_CNT_W)) u_err_cnt (
    .clk_i   (PCLK),
    .rst_i   (RESET),
    .clr_i   (clear),
    .inc_i   (|viol),
    .count_o (err_count)
  );

  assign err_pulse  = err_pulse_q;
  assign err_code   = err_code_q;
  assign err_addr   = err_addr_q;
  assign err_sticky = err_sticky_q;

endmodule
